// File: rtl/ring_pkg.sv
// Shared types and constants for the ring counter monitor.
//   state_e      : monitor FSM state encoding
//   RingWDefault : default ring width in bits
package ring_pkg;

    localparam int unsigned RingWDefault = 4;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StTrack,
        StFault
    } state_e;

endpackage

// File: rtl/ring_monitor_if.sv
// Bus bundle between a ring counter sampler and ring_monitor.
//   in        : ring counter sample
//   valid     : sample qualifier
//   clear     : synchronous clear of monitor state and counters
//   locked    : ring is rotating correctly
//   fault     : rotation error
//   rev_tick  : one-cycle pulse per completed revolution
//   rev_count : completed revolutions since lock (wrapping)
// master drives samples, slave is the monitor.
interface ring_monitor_if
    import ring_pkg::*;
#(
    parameter int unsigned RING_W = RingWDefault,
    parameter int unsigned REV_W  = 8
);

    logic [RING_W-1:0] in;
    logic              valid;
    logic              clear;
    logic              locked;
    logic              fault;
    logic              rev_tick;
    logic [REV_W-1:0]  rev_count;

    modport master (
        output in, valid, clear,
        input  locked, fault, rev_tick, rev_count
    );

    modport slave (
        input  in, valid, clear,
        output locked, fault, rev_tick, rev_count
    );

endinterface

// File: rtl/ring_rot_cmp.sv
// Combinational rotation checker.
//   prev_i    : previously accepted sample
//   sample_i  : current sample
//   match_o   : sample_i equals prev_i rotated right by one (and is legal)
//   illegal_o : sample_i is all zero (no ring present)
module ring_rot_cmp
    import ring_pkg::*;
#(
    parameter int unsigned RING_W = RingWDefault
) (
    input  logic [RING_W-1:0] prev_i,
    input  logic [RING_W-1:0] sample_i,
    output logic              match_o,
    output logic              illegal_o
);

    logic [RING_W-1:0] expected;

    always_comb begin
        expected  = {prev_i[0], prev_i[RING_W-1:1]};
        illegal_o = (sample_i == '0);
        match_o   = !illegal_o && (sample_i == expected);
    end

endmodule

// File: rtl/ring_monitor.sv
// Ring counter rotation monitor.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : ring_monitor_if slave (in/valid/clear in; locked/fault/rev_tick/rev_count out)
// A revolution is RING_W consecutive matching rotations counted from the
// sample that achieved lock. All outputs are registered.
// Build option: define RING_MON_RECOVER_EN to let FAULT resync on the next
// accepted sample; otherwise FAULT is left only by clear or reset.
module ring_monitor
    import ring_pkg::*;
#(
    parameter int unsigned RING_W = RingWDefault,
    parameter int unsigned REV_W  = 8
) (
    input logic          clk,
    input logic          reset,
    ring_monitor_if.slave bus
);

    localparam int unsigned StepW = (RING_W > 1) ? $clog2(RING_W) : 1;

    state_e            state_q, state_d;
    logic [RING_W-1:0] prev_q, prev_d;
    logic [StepW-1:0]  step_q, step_d;
    logic [REV_W-1:0]  count_q, count_d;
    logic              locked_q, locked_d;
    logic              fault_q, fault_d;
    logic              tick_q, tick_d;
    logic              match, illegal;

    ring_rot_cmp #(
        .RING_W (RING_W)
    ) u_rot_cmp (
        .prev_i    (prev_q),
        .sample_i  (bus.in),
        .match_o   (match),
        .illegal_o (illegal)
    );

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        step_d  = step_q;
        count_d = count_q;
        tick_d  = 1'b0;

        if (bus.clear) begin
            state_d = StIdle;
            prev_d  = '0;
            step_d  = '0;
            count_d = '0;
        end else if (bus.valid) begin
            unique case (state_q)
                StIdle: begin
                    if (!illegal) begin
                        prev_d  = bus.in;
                        state_d = StSync;
                    end
                end
                StSync: begin
                    if (illegal) begin
                        state_d = StIdle;
                    end else begin
                        prev_d = bus.in;
                        if (match) begin
                            // Lock restarts the revolution count.
                            state_d = StTrack;
                            step_d  = StepW'(1);
                            count_d = '0;
                        end
                    end
                end
                StTrack: begin
                    if (match) begin
                        prev_d = bus.in;
                        if (step_q == StepW'(RING_W - 1)) begin
                            step_d  = '0;
                            tick_d  = 1'b1;
                            count_d = count_q + REV_W'(1);
                        end else begin
                            step_d = step_q + StepW'(1);
                        end
                    end else begin
                        state_d = StFault;
                    end
                end
                StFault: begin
`ifdef RING_MON_RECOVER_EN
                    if (illegal) begin
                        state_d = StIdle;
                    end else begin
                        prev_d  = bus.in;
                        state_d = StSync;
                    end
`endif
                end
                default: state_d = StIdle;
            endcase
        end

        locked_d = (state_d == StTrack);
        fault_d  = (state_d == StFault);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            prev_q   <= '0;
            step_q   <= '0;
            count_q  <= '0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            step_q   <= step_d;
            count_q  <= count_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
            tick_q   <= tick_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.fault     = fault_q;
    assign bus.rev_tick  = tick_q;
    assign bus.rev_count = count_q;

endmodule
